clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-2 block in the frequency-eliminator chain. It divides `clk` by any integer N from 2 to 2^WIDTH-1 and offers a square-wave mode and a single-pulse mode. Ratio changes take effect only at a period boundary, so `clk_o` is glitch-free. It also provides a period-start strobe for downstream sequencing logic.

---
 rtl/clk_div_prog.sv | 84 ++++++++
 tb/tb_clk_div_prog.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (N = 2 .. 2^WIDTH-1) with square-wave
// and single-pulse modes; ratio changes are deferred to a period boundary.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_o,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] high_cnt;
  logic             wrap;
  logic             accept;

  always_comb begin
    wrap     = (cnt == div_active - 1'b1);
    cnt_next = wrap ? '0 : cnt + 1'b1;
    // Odd N rounds the high phase up: N - floor(N/2).
    high_cnt = div_active - (div_active >> 1);
    accept   = div_load && (div_in >= MIN_DIV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      clk_o      <= 1'b0;
      tick       <= 1'b0;
      div_active <= DEF_DIV;
      pend_val   <= DEF_DIV;
      pending    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= div_load && !accept;
      if (en) begin
        if (wrap && (accept || pending)) begin
          // A load arriving on the boundary edge takes priority over the stored one.
          div_active <= accept ? div_in : pend_val;
          if (accept) pend_val <= div_in;
          pending <= 1'b0;
          cnt     <= '0;
          tick    <= 1'b1;
          clk_o   <= 1'b1;
        end else begin
          cnt   <= cnt_next;
          tick  <= (cnt_next == '0);
          clk_o <= mode ? (cnt_next == '0) : (cnt_next < high_cnt);
          if (accept) begin
            pend_val <= div_in;
            pending  <= 1'b1;
          end
        end
      end else begin
        tick <= 1'b0;
        // Frozen divider: flush any stored request so it is never stranded.
        if (pending) begin
          div_active <= pend_val;
          cnt        <= '0;
          clk_o      <= 1'b0;
          pending    <= 1'b0;
        end
        if (accept) begin
          pend_val <= div_in;
          pending  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios followed by random traffic, all
// checked against an arithmetic model of period position, divisor and request queue.
module tb_clk_div_prog;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             clk_o, tick, pending, err;
  logic [WIDTH-1:0] cnt, div_active;

  int checks = 0;
  int failures = 0;

  // Reference model state: position within the period, divisor, outstanding request.
  int m_pos, m_n, m_clk, m_tick, m_err;
  int pend_q[$];

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div_in(div_in),
    .div_load(div_load), .clk_o(clk_o), .tick(tick), .cnt(cnt),
    .div_active(div_active), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_n = DEFAULT_DIV; m_clk = 0; m_tick = 0; m_err = 0;
    pend_q.delete();
  endtask

  // Output level from period position: first ceil(N/2) positions high, or a pulse at 0.
  function automatic int level(input int pos, input int n, input logic md);
    return md ? int'(pos == 0) : int'(pos < (n + 1) / 2);
  endfunction

  task automatic model_edge();
    int good;
    good  = int'(div_load) && (int'(div_in) >= 2);
    m_err = int'(div_load) && !good;
    if (en) begin
      if ((m_pos == m_n - 1) && (good || pend_q.size() > 0)) begin
        m_n = good ? int'(div_in) : pend_q[0];
        pend_q.delete();
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % m_n;
        if (good) begin pend_q.delete(); pend_q.push_back(int'(div_in)); end
      end
      m_tick = int'(m_pos == 0);
      m_clk  = level(m_pos, m_n, mode);
    end else begin
      m_tick = 0;
      if (pend_q.size() > 0) begin
        m_n = pend_q[0];
        pend_q.delete();
        m_pos = 0;
        m_clk = 0;
      end
      if (good) begin pend_q.delete(); pend_q.push_back(int'(div_in)); end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"}, int'(cnt), m_pos);
    chk({tag, ".clk_o"}, int'(clk_o), m_clk);
    chk({tag, ".tick"}, int'(tick), m_tick);
    chk({tag, ".div_active"}, int'(div_active), m_n);
    chk({tag, ".pending"}, int'(pending), int'(pend_q.size() > 0));
    chk({tag, ".err"}, int'(err), m_err);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic load(input string tag, input int v);
    div_in = WIDTH'(v);
    div_load = 1'b1;
    step(tag);
    div_load = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Default N=2: clk_o toggles every edge, tick every second edge.
    en = 1'b1;
    steps("n2", 6);

    // N=5 square wave: 3 high / 2 low once the current period ends.
    load("ld5", 5);
    steps("n5", 14);

    // Two loads before the boundary: only the last one ever appears.
    load("ld6", 6);
    load("ld9", 9);
    steps("n9", 20);

    // Rejected loads pulse err without disturbing anything.
    load("bad1", 1);
    steps("after_bad1", 2);
    load("bad0", 0);
    steps("after_bad0", 4);

    // Pulse mode N=4, freeze mid-period, load while frozen.
    mode = 1'b1;
    load("ld4", 4);
    steps("n4", 13);
    while (m_pos != 1) step("align4");
    en = 1'b0;
    steps("frozen", 3);
    load("ld3_frozen", 3);
    step("apply_frozen");
    en = 1'b1;
    steps("n3_pulse", 9);

    // Reset mid-period with a request outstanding.
    while (m_pos != 0) step("align3");
    load("ld7", 7);
    chk("pending_before_rst", int'(pending), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    mode = 1'b0;
    steps("post_rst", 8);

    // Random traffic: sparse loads (including illegal values), enable gaps, mode flips.
    for (int i = 0; i < 800; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 11) == 0);
      div_in   = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step("rand");
    end
    div_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
